sdram_arbiter: RTL and testbench
================================

# sdram_arbiter

Slot scheduler between the picosoc bus masters and the `sdram` controller. It shares the single SDRAM port between a 32-bit CPU port (picorv32 native memory handshake) and a 16-bit read-only DMA port. Each 32-bit CPU access is split into 16-bit halfword slots. The block generates the `clkref` slot reference and inserts idle slots so that the controller issues auto-refresh.

## Interface
Parameters:
- `RD_PHASE`, 12: phase at which `sd_dout` is sampled; legal range 1..13.
- `REFRESH_MAX`, 40: maximum consecutive non-idle slots before an idle (refresh) slot is forced.

Ports:
- `clk` in 1: system clock, which is also the SDRAM controller clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `cpu_valid` in 1: CPU request; held until `cpu_ready`.
- `cpu_ready` out 1: one-cycle completion pulse.
- `cpu_addr` in 25: byte address; bits [1:0] ignored.
- `cpu_wdata` in 32: write data.
- `cpu_wstrb` in 4: byte write enables; 0 means read.
- `cpu_rdata` out 32: read data, valid while `cpu_ready` is high and held afterwards.
- `dma_valid` in 1: DMA read request; held until `dma_ready`.
- `dma_ready` out 1: one-cycle completion pulse.
- `dma_addr` in 25: byte address; bit 0 ignored.
- `dma_rdata` out 16: read data, held.
- `sd_clkref` out 1: slot reference to the controller.
- `sd_addr` out 25: halfword byte address; bit 0 is always 0.
- `sd_we` out 1: write request.
- `sd_oe` out 1: read request.
- `sd_dqm` out 2: byte enables, active-high; meaningful only when `sd_we` is 1.
- `sd_din` out 16: write data.
- `sd_dout` in 16: read data from the controller.

## Operation
- **Phase counter:** 4-bit `ph` counts 0..15 and wraps.
  - `sd_clkref` = 1 for ph 8..15 and 0 for ph 0..7. This is a square wave with a 16-clk period.
- **Arbitration edge:** the clock edge at which ph==15. All `sd_*` request outputs are registered and load only on this edge, so they are stable for a whole slot (ph 0..15).
- **Slot states:** IDLE, CPU_LO, CPU_HI, DMA.
  - IDLE drives `sd_we`=`sd_oe`=0. The controller performs auto-refresh in that slot.
  - CPU_LO addresses `{cpu_addr[24:2],2'b00}` and drives `sd_din`=`cpu_wdata[15:0]` and `sd_dqm`=`cpu_wstrb[1:0]`.
  - CPU_HI addresses `{cpu_addr[24:2],2'b10}` and drives `cpu_wdata[31:16]` and `cpu_wstrb[3:2]`.
  - DMA addresses `{dma_addr[24:1],1'b0}` with `sd_oe`=1 and `sd_we`=0.
- **Write slots:** `sd_we`=1 and `sd_oe`=0.
- **CPU read slots:** `sd_oe`=1 and `sd_we`=0.
- **Next state, chosen at the arbitration edge in priority order:**
  1. If the current state is CPU_LO and a CPU_HI half is still needed, go to CPU_HI. The CPU pair is never split.
  2. If `busy_cnt` ≥ REFRESH_MAX, go to IDLE.
  3. If both ports are requesting, grant the port not granted last (round-robin). A CPU grant enters CPU_LO, or CPU_HI directly for a write with `cpu_wstrb[1:0]`==0.
  4. If one port is requesting, grant it.
  5. Otherwise go to IDLE.
- **Write halfword skipping:**
  - A write with `cpu_wstrb[3:2]`==0 uses only CPU_LO.
  - A write with `cpu_wstrb[1:0]`==0 uses only CPU_HI.
  - A read always uses both slots.
- **`busy_cnt` (6 bits, saturating):**
  - Increments on every non-IDLE slot entry.
  - Clears on IDLE entry.
  - The worst case is REFRESH_MAX+1 consecutive busy slots, reached when a CPU pair straddles the limit.
- **Read capture:** on the edge where ph==RD_PHASE:
  - In CPU_LO, load `cpu_rdata[15:0]`.
  - In CPU_HI, load `cpu_rdata[31:16]`.
  - In DMA, load `dma_rdata`.
- **Completion:** `cpu_ready` (or `dma_ready`) is 1 for exactly the cycle after the RD_PHASE edge of the final slot of the transaction. This applies to both reads and writes.
  - Because RD_PHASE ≤ 13, the master drops `valid` before the next arbitration edge, so a request is never granted twice.
- **Reset (resetn=0, asynchronous):**
  - All outputs go to 0 (`sd_clkref`, `sd_we`, `sd_oe`, `sd_dqm`, `sd_addr`, `sd_din`, readys, rdata).
  - ph=0, state=IDLE, `busy_cnt`=0, and the last-grant pointer is set to DMA so the CPU wins the first tie.
- **Reset mid-slot:** the in-flight access is abandoned and no ready is issued. Contents at the target address are undefined if a write was in progress.

## Timing
- A request must be high before the arbitration edge to be considered for the next slot.
- CPU read latency: `cpu_ready` at ph RD_PHASE+1 of the second granted slot, i.e. 16+RD_PHASE+1 clocks after the first slot starts.
- Single-halfword write or DMA latency: ready at ph RD_PHASE+1 of the granted slot.
- Worst-case wait before a grant:
  - CPU waits for one DMA slot plus one forced IDLE slot plus the current slot.
  - DMA waits for one CPU pair plus one IDLE slot plus the current slot.
- All outputs are registered. There is no combinational path from an input to an output.

## Test plan
- **Reset mid-slot:** pull resetn low at ph 5 of a CPU_LO write → all outputs 0 immediately. After release, `sd_clkref` is 0 for 8 clks then 1 for 8 clks; no `cpu_ready` is issued.
- **CPU read:** `cpu_addr`=0x000104, `cpu_wstrb`=0, `sd_dout` returns 0x1111 then 0x2222 → slots at `sd_addr` 0x000104 then 0x000106 with `sd_oe`=1. `cpu_rdata`=0x22221111 and `cpu_ready` is high for 1 clk at ph RD_PHASE+1 of slot 2.
- **Partial CPU write:** `cpu_wstrb`=4'b1100, `cpu_wdata`=0xAABBCCDD, `cpu_addr`=0x000200 → exactly one slot with `sd_addr`=0x000202, `sd_din`=0xAABB, `sd_dqm`=2'b11, `sd_we`=1, followed by `cpu_ready`.
- **Contention:** `cpu_valid` and `dma_valid` held continuously (masters re-request immediately) → slot sequence CPU_LO, CPU_HI, DMA, CPU_LO, CPU_HI, DMA…; no DMA slot ever falls between CPU_LO and CPU_HI.
- **Forced refresh:** DMA continuously requesting → after 40 consecutive DMA slots, slot 41 is IDLE (`sd_oe`=`sd_we`=0) and DMA resumes in slot 42.
- **Refresh limit during a CPU pair:** `busy_cnt` reaches 40 while in CPU_LO → CPU_HI completes first, the next slot is IDLE, and `busy_cnt` then reads 0.

Source files
------------

// File: rtl/sdram_arbiter_if.sv
// Signal bundle between the picosoc CPU/DMA masters, the slot arbiter and the
// SDRAM controller. The arbiter takes the slave view; the environment takes the master view.
interface sdram_arbiter_if;
  logic        cpu_valid;
  logic        cpu_ready;
  logic [24:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic [31:0] cpu_rdata;

  logic        dma_valid;
  logic        dma_ready;
  logic [24:0] dma_addr;
  logic [15:0] dma_rdata;

  logic        sd_clkref;
  logic [24:0] sd_addr;
  logic        sd_we;
  logic        sd_oe;
  logic [1:0]  sd_dqm;
  logic [15:0] sd_din;
  logic [15:0] sd_dout;

  modport slave (
    input  cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
    input  dma_valid, dma_addr,
    input  sd_dout,
    output cpu_ready, cpu_rdata,
    output dma_ready, dma_rdata,
    output sd_clkref, sd_addr, sd_we, sd_oe, sd_dqm, sd_din
  );

  modport master (
    output cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
    output dma_valid, dma_addr,
    output sd_dout,
    input  cpu_ready, cpu_rdata,
    input  dma_ready, dma_rdata,
    input  sd_clkref, sd_addr, sd_we, sd_oe, sd_dqm, sd_din
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Time-slot scheduler sharing one 16-bit SDRAM port between a 32-bit CPU port and a
// 16-bit read-only DMA port, with forced idle slots so the controller can refresh.
module sdram_arbiter #(
  parameter int RD_PHASE    = 12,
  parameter int REFRESH_MAX = 40
) (
  input  logic           clk,
  input  logic           resetn,
  sdram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_CPU_LO, ST_CPU_HI, ST_DMA} slot_e;

  localparam logic [3:0] LP_RD_PH   = 4'(RD_PHASE);
  localparam logic [5:0] LP_REF_MAX = 6'(REFRESH_MAX);

  logic [3:0]  r_ph;
  slot_e       r_state;
  slot_e       w_state_next;
  logic        r_last_dma;
  logic        r_need_hi;
  logic [5:0]  r_busy_cnt;

  logic        r_clkref;
  logic        r_sd_we;
  logic        r_sd_oe;
  logic [1:0]  r_sd_dqm;
  logic [24:0] r_sd_addr;
  logic [15:0] r_sd_din;
  logic        r_cpu_ready;
  logic        r_dma_ready;
  logic [31:0] r_cpu_rdata;
  logic [15:0] r_dma_rdata;

  logic        w_sd_we;
  logic        w_sd_oe;
  logic [1:0]  w_sd_dqm;
  logic [24:0] w_sd_addr;
  logic [15:0] w_sd_din;

  logic        w_arb_edge;
  logic        w_rd_edge;
  logic [3:0]  w_ph_next;
  logic        w_cpu_wr;
  logic        w_cpu_need_hi;
  slot_e       w_cpu_slot;
  logic        w_unused;

  assign w_arb_edge    = (r_ph == 4'hF);
  assign w_rd_edge     = (r_ph == LP_RD_PH);
  assign w_ph_next     = r_ph + 4'd1;
  assign w_cpu_wr      = |bus.cpu_wstrb;
  assign w_cpu_need_hi = !w_cpu_wr || (bus.cpu_wstrb[3:2] != 2'b00);
  // A write touching only the upper halfword skips straight to the high slot.
  assign w_cpu_slot    = (w_cpu_wr && bus.cpu_wstrb[1:0] == 2'b00) ? ST_CPU_HI : ST_CPU_LO;
  // Sub-halfword address bits carry no information for a 16-bit port.
  assign w_unused      = &{1'b0, bus.cpu_addr[1:0], bus.dma_addr[0]};

  // Next slot: only decided at the arbitration edge, otherwise the slot holds.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (latch).
    w_state_next = r_state;
    if (w_arb_edge) begin
      if (r_state == ST_CPU_LO && r_need_hi)           w_state_next = ST_CPU_HI;
      else if (r_busy_cnt >= LP_REF_MAX)               w_state_next = ST_IDLE;
      else if (bus.cpu_valid && bus.dma_valid)         w_state_next = r_last_dma ? w_cpu_slot : ST_DMA;
      else if (bus.cpu_valid)                          w_state_next = w_cpu_slot;
      else if (bus.dma_valid)                          w_state_next = ST_DMA;
      else                                             w_state_next = ST_IDLE;
    end
  end

  // Request decode for the slot being entered; registered at the arbitration edge.
  always_comb begin
    w_sd_we   = 1'b0;
    w_sd_oe   = 1'b0;
    w_sd_dqm  = 2'b00;
    w_sd_addr = '0;
    w_sd_din  = '0;
    unique case (w_state_next)
      ST_CPU_LO: begin
        w_sd_addr = {bus.cpu_addr[24:2], 2'b00};
        w_sd_din  = bus.cpu_wdata[15:0];
        w_sd_dqm  = bus.cpu_wstrb[1:0];
        w_sd_we   = w_cpu_wr;
        w_sd_oe   = !w_cpu_wr;
      end
      ST_CPU_HI: begin
        w_sd_addr = {bus.cpu_addr[24:2], 2'b10};
        w_sd_din  = bus.cpu_wdata[31:16];
        w_sd_dqm  = bus.cpu_wstrb[3:2];
        w_sd_we   = w_cpu_wr;
        w_sd_oe   = !w_cpu_wr;
      end
      ST_DMA: begin
        w_sd_addr = {bus.dma_addr[24:1], 1'b0};
        w_sd_oe   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_last_dma <= 1'b1;
      r_need_hi  <= 1'b0;
      r_busy_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state <= w_state_next;
      if (w_arb_edge) begin
        r_need_hi <= w_cpu_need_hi;
        if (w_state_next == ST_DMA)
          r_last_dma <= 1'b1;
        else if (w_state_next != ST_IDLE)
          r_last_dma <= 1'b0;
        if (w_state_next == ST_IDLE)
          r_busy_cnt <= '0;
        else if (r_busy_cnt != 6'h3F)
          r_busy_cnt <= r_busy_cnt + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ph        <= '0;
      r_clkref    <= 1'b0;
      r_sd_we     <= 1'b0;
      r_sd_oe     <= 1'b0;
      r_sd_dqm    <= '0;
      r_sd_addr   <= '0;
      r_sd_din    <= '0;
      r_cpu_ready <= 1'b0;
      r_dma_ready <= 1'b0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      r_ph     <= w_ph_next;
      r_clkref <= w_ph_next[3];
      if (w_arb_edge) begin
        r_sd_we   <= w_sd_we;
        r_sd_oe   <= w_sd_oe;
        r_sd_dqm  <= w_sd_dqm;
        r_sd_addr <= w_sd_addr;
        r_sd_din  <= w_sd_din;
      end
      // Ready follows the capture edge of the last slot a transaction occupies.
      r_cpu_ready <= w_rd_edge && ((r_state == ST_CPU_LO && !r_need_hi) || r_state == ST_CPU_HI);
      r_dma_ready <= w_rd_edge && (r_state == ST_DMA);
      if (w_rd_edge) begin
        if (r_state == ST_CPU_LO) r_cpu_rdata[15:0]  <= bus.sd_dout;
        if (r_state == ST_CPU_HI) r_cpu_rdata[31:16] <= bus.sd_dout;
        if (r_state == ST_DMA)    r_dma_rdata        <= bus.sd_dout;
      end
    end
  end

  assign bus.sd_clkref = r_clkref;
  assign bus.sd_we     = r_sd_we;
  assign bus.sd_oe     = r_sd_oe;
  assign bus.sd_dqm    = r_sd_dqm;
  assign bus.sd_addr   = r_sd_addr;
  assign bus.sd_din    = r_sd_din;
  assign bus.cpu_ready = r_cpu_ready;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.dma_ready = r_dma_ready;
  assign bus.dma_rdata = r_dma_rdata;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: reset, CPU read, partial write, mid-slot reset,
// contention round-robin, forced refresh and a CPU pair straddling the refresh limit.
module tb_sdram_arbiter;
  localparam int RD_PHASE    = 12;
  localparam int REFRESH_MAX = 40;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;
  logic [3:0] tb_ph;
  bit   drop_cpu;
  bit   drop_dma;

  typedef struct {
    logic [24:0] addr;
    logic        we;
    logic        oe;
    logic [1:0]  dqm;
    logic [15:0] din;
    int          cpu_rdy_cnt;
    int          cpu_rdy_ph;
    int          dma_rdy_cnt;
    logic [31:0] cpu_rdata;
    logic [15:0] dma_rdata;
  } slot_t;

  sdram_arbiter_if bus();

  sdram_arbiter #(.RD_PHASE(RD_PHASE), .REFRESH_MAX(REFRESH_MAX)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Independent phase model: 16-clock slots counted from reset release.
  always @(posedge clk or negedge resetn)
    if (!resetn) tb_ph <= 4'd0;
    else         tb_ph <= tb_ph + 4'd1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ctl"}, {25'd0, bus.sd_clkref, bus.sd_we, bus.sd_oe, bus.sd_dqm,
                          bus.cpu_ready, bus.dma_ready}, 32'd0);
    check({tag, ".addr"}, {7'd0, bus.sd_addr}, 32'd0);
    check({tag, ".din"}, {bus.sd_din, bus.dma_rdata}, 32'd0);
    check({tag, ".rdata"}, bus.cpu_rdata, 32'd0);
  endtask

  // Starts at the negedge right after reset release; ends at ph0 of the next slot.
  task automatic check_clkref_period(input string tag);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      check({tag, ".clkref"}, {31'd0, bus.sd_clkref}, {31'd0, (k >= 8)});
      check({tag, ".rdy"}, {30'd0, bus.cpu_ready, bus.dma_ready}, 32'd0);
    end
    @(negedge clk);
  endtask

  // Called at the negedge of ph0; observes one whole slot and returns at ph0 of the next.
  task automatic run_slot(input logic [15:0] dout, output slot_t s);
    s.addr        = bus.sd_addr;
    s.we          = bus.sd_we;
    s.oe          = bus.sd_oe;
    s.dqm         = bus.sd_dqm;
    s.din         = bus.sd_din;
    s.cpu_rdy_cnt = 0;
    s.cpu_rdy_ph  = -1;
    s.dma_rdy_cnt = 0;
    s.cpu_rdata   = '0;
    s.dma_rdata   = '0;
    bus.sd_dout   = dout;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.cpu_ready) begin
        s.cpu_rdy_cnt += 1;
        s.cpu_rdy_ph   = int'(tb_ph);
        s.cpu_rdata    = bus.cpu_rdata;
        if (drop_cpu) bus.cpu_valid = 1'b0;
      end
      if (bus.dma_ready) begin
        s.dma_rdy_cnt += 1;
        s.dma_rdata    = bus.dma_rdata;
        if (drop_dma) bus.dma_valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic expect_idle(input string tag, input slot_t s);
    check({tag, ".req"}, {30'd0, s.we, s.oe}, 32'd0);
  endtask

  task automatic expect_slot(input string tag, input slot_t s, input logic we, input logic oe,
                             input logic [24:0] addr, input logic [1:0] dqm, input logic [15:0] din);
    check({tag, ".req"}, {30'd0, s.we, s.oe}, {30'd0, we, oe});
    check({tag, ".addr"}, {7'd0, s.addr}, {7'd0, addr});
    if (we) check({tag, ".wr"}, {14'd0, s.dqm, s.din}, {14'd0, dqm, din});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    slot_t s;
    int    good;
    int    rdy;

    bus.cpu_valid = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cpu_wstrb = '0;
    bus.dma_valid = 1'b0;
    bus.dma_addr  = '0;
    bus.sd_dout   = '0;
    drop_cpu      = 1'b1;
    drop_dma      = 1'b1;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    resetn = 1'b1;
    check_clkref_period("boot");

    // CPU read split into two halfword slots
    bus.cpu_addr  = 25'h000104;
    bus.cpu_wstrb = 4'b0000;
    bus.cpu_wdata = 32'hFFFF_FFFF;
    bus.cpu_valid = 1'b1;
    run_slot(16'h0000, s); expect_idle("rd.pre", s);
    run_slot(16'h1111, s); expect_slot("rd.lo", s, 1'b0, 1'b1, 25'h000104, 2'b00, 16'h0);
    check("rd.lo.rdy", s.cpu_rdy_cnt, 0);
    run_slot(16'h2222, s); expect_slot("rd.hi", s, 1'b0, 1'b1, 25'h000106, 2'b00, 16'h0);
    check("rd.hi.rdy", s.cpu_rdy_cnt, 1);
    check("rd.hi.ph", s.cpu_rdy_ph, RD_PHASE + 1);
    check("rd.data", s.cpu_rdata, 32'h22221111);

    // Upper-halfword-only write uses a single CPU_HI slot
    bus.cpu_addr  = 25'h000200;
    bus.cpu_wdata = 32'hAABBCCDD;
    bus.cpu_wstrb = 4'b1100;
    bus.cpu_valid = 1'b1;
    run_slot(16'h0BAD, s); expect_idle("wr.pre", s);
    run_slot(16'h0BAD, s); expect_slot("wr.hi", s, 1'b1, 1'b0, 25'h000202, 2'b11, 16'hAABB);
    check("wr.rdy", s.cpu_rdy_cnt, 1);
    check("wr.ph", s.cpu_rdy_ph, RD_PHASE + 1);

    // Mid-slot reset during a full-word write
    bus.cpu_addr  = 25'h000300;
    bus.cpu_wdata = 32'h12345678;
    bus.cpu_wstrb = 4'b1111;
    bus.cpu_valid = 1'b1;
    run_slot(16'h0000, s); expect_idle("wr.post", s);
    check("mr.slot", {bus.sd_we, bus.sd_oe, bus.sd_dqm, 3'd0, bus.sd_addr},
          {1'b1, 1'b0, 2'b11, 3'd0, 25'h000300});
    check("mr.din", {16'd0, bus.sd_din}, 32'h00005678);
    repeat (5) @(negedge clk);
    resetn        = 1'b0;
    bus.cpu_valid = 1'b0;
    #1;
    check_all_zero("mid_rst");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    check_clkref_period("rst_rel");

    // Contention: both held, CPU wins the first tie, pairs never split
    drop_cpu      = 1'b0;
    drop_dma      = 1'b0;
    bus.cpu_addr  = 25'h000400;
    bus.cpu_wstrb = 4'b0000;
    bus.cpu_valid = 1'b1;
    bus.dma_addr  = 25'h001001;
    bus.dma_valid = 1'b1;
    run_slot(16'h0000, s); expect_idle("ct.pre", s);
    check("ct.pre.rdy", s.cpu_rdy_cnt + s.dma_rdy_cnt, 0);
    run_slot(16'hA001, s); expect_slot("ct.lo1", s, 1'b0, 1'b1, 25'h000400, 2'b00, 16'h0);
    run_slot(16'hA002, s); expect_slot("ct.hi1", s, 1'b0, 1'b1, 25'h000402, 2'b00, 16'h0);
    check("ct.cpu1", s.cpu_rdata, 32'hA002A001);
    run_slot(16'hB003, s); expect_slot("ct.dma1", s, 1'b0, 1'b1, 25'h001000, 2'b00, 16'h0);
    check("ct.dmad1", {16'd0, s.dma_rdata}, 32'h0000B003);
    check("ct.dmar1", s.dma_rdy_cnt, 1);
    run_slot(16'hA004, s); expect_slot("ct.lo2", s, 1'b0, 1'b1, 25'h000400, 2'b00, 16'h0);
    drop_cpu = 1'b1;
    run_slot(16'hA005, s); expect_slot("ct.hi2", s, 1'b0, 1'b1, 25'h000402, 2'b00, 16'h0);
    check("ct.cpu2", s.cpu_rdata, 32'hA005A004);
    drop_dma = 1'b1;
    run_slot(16'hB006, s); expect_slot("ct.dma2", s, 1'b0, 1'b1, 25'h001000, 2'b00, 16'h0);
    check("ct.dmad2", {16'd0, s.dma_rdata}, 32'h0000B006);

    // Forced refresh after REFRESH_MAX consecutive DMA slots
    bus.dma_addr  = 25'h002003;
    bus.dma_valid = 1'b1;
    drop_dma      = 1'b0;
    run_slot(16'h0000, s); expect_idle("rf.pre", s);
    good = 0;
    rdy  = 0;
    for (int j = 0; j < REFRESH_MAX; j++) begin
      run_slot(16'(j), s);
      if (s.oe && !s.we && s.addr == 25'h002002) good++;
      rdy += s.dma_rdy_cnt;
    end
    check("rf.run1", good, 40);
    check("rf.rdy1", rdy, 40);
    run_slot(16'h0000, s); expect_idle("rf.forced", s);

    // CPU pair entered with the busy count reaching the limit in CPU_LO
    good = 0;
    for (int j = 0; j < REFRESH_MAX - 1; j++) begin
      if (j == REFRESH_MAX - 2) begin
        bus.cpu_addr  = 25'h000504;
        bus.cpu_wstrb = 4'b0000;
        bus.cpu_valid = 1'b1;
      end
      run_slot(16'(j), s);
      if (s.oe && !s.we && s.addr == 25'h002002) good++;
    end
    check("rf.run2", good, 39);
    run_slot(16'h5555, s); expect_slot("st.lo", s, 1'b0, 1'b1, 25'h000504, 2'b00, 16'h0);
    run_slot(16'h6666, s); expect_slot("st.hi", s, 1'b0, 1'b1, 25'h000506, 2'b00, 16'h0);
    check("st.data", s.cpu_rdata, 32'h66665555);
    run_slot(16'h0000, s); expect_idle("st.idle", s);
    good = 0;
    for (int j = 0; j < REFRESH_MAX; j++) begin
      run_slot(16'(j), s);
      if (s.oe && !s.we && s.addr == 25'h002002) good++;
    end
    check("st.run3", good, 40);
    run_slot(16'h0000, s); expect_idle("st.idle2", s);

    bus.dma_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
